sa_row_feeder: RTL and testbench
================================

# sa_row_feeder

Input-side skew feeder for the weight-stationary convolution systolic array (`SA_WS_conv`). It accepts one tile of `VECTOR_LENGTH` unskewed activation vectors (one element per array row) over a valid/ready handshake and buffers the tile. It then drives the array's `sa_iv`/`row_A_i` port with the diagonal skew the array requires: row r is delayed r cycles, with zero padding outside the tile. It is the transmitter for the array's activation input.

## Interface
- `SA_ROW`, 3: number of array rows, equal to the elements per input vector.
- `DATA_WIDTH`, 8: element width. Signed two's complement; passed through unmodified.
- `VECTOR_LENGTH`, 8: vectors per tile. Must be ≥ 1.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_vec` is valid.
- `in_ready`  out  1: the feeder can accept a vector.
- `in_vec`  in  `[SA_ROW-1:0][DATA_WIDTH-1:0]`: element r is destined for array row r.
- `in_last`  in  1: qualifies the accepted vector as the final one of a short tile.
- `sa_iv`  out  1: array input valid. Connects to the array's `sa_iv`.
- `row_A_i`  out  `[SA_ROW-1:0][DATA_WIDTH-1:0]`: skewed activations. Connects to the array's `row_A_i`.
- `tile_done`  out  1: one-cycle pulse when a tile has been fully streamed.

## Operation
- **States.** `LOAD` and `STREAM`. Reset enters `LOAD` with vector count `cnt` = 0.
- **Acceptance.** A vector is accepted on a rising edge where `in_valid & in_ready`.
- **`LOAD`.**
  - `in_ready` = 1.
  - Each accepted vector is written to `buf[cnt]`, then `cnt` increments.
  - Leave for `STREAM` on the accept where `cnt == VECTOR_LENGTH-1` or `in_last` = 1.
  - On an early `in_last`, slots `cnt+1 .. VECTOR_LENGTH-1` are treated as zero vectors. The stored buffer is not read for those slots.
- **`STREAM`.**
  - `in_ready` = 0. Input is ignored.
  - Step counter `t` runs 0 .. `VECTOR_LENGTH+SA_ROW-2`, which is `VECTOR_LENGTH+SA_ROW-1` cycles in total.
  - Each cycle: `sa_iv` = 1, and `row_A_i[r]` = `buf[t-r][r]` if 0 ≤ `t-r` < `VECTOR_LENGTH` and slot `t-r` was loaded; otherwise 0.
  - After the last step, return to `LOAD` with `cnt` = 0 and pulse `tile_done`.
- **Idle outputs.** Outside `STREAM`, `sa_iv` = 0 and `row_A_i` = all zeros.
- **Buffer.** `VECTOR_LENGTH × SA_ROW × DATA_WIDTH` bits, single-buffered. It is not cleared between tiles; the padding rule alone guarantees zeros.
- **Arithmetic.** `cnt` and `t` are wide enough to hold `VECTOR_LENGTH+SA_ROW-1`. There is no data arithmetic.

## Timing
- `sa_iv` and `row_A_i` are registered.
- **Tile start.** The first `STREAM` output cycle (t = 0) begins on the edge immediately after the edge that accepted the tile's final vector. Latency is 1 cycle. For `VECTOR_LENGTH` = 1, the vector accepted on that same edge must appear at t = 0, so it is forwarded directly.
- **`in_ready` timing.**
  - Falls on the same edge the final vector is accepted.
  - Rises on the same edge `sa_iv` falls.
  - Stays 0 for exactly `VECTOR_LENGTH+SA_ROW-1` cycles.
- **`tile_done`.** High for the single cycle following the last `STREAM` cycle, i.e. the first cycle with `sa_iv` = 0. `in_ready` = 1 in that same cycle, so a new vector may be accepted then.
- **Back-to-back tiles.** The minimum gap between tiles is the load time. A tile of N vectors delivered at full rate (no gaps) occupies N + `VECTOR_LENGTH+SA_ROW-1` cycles.
- **Input gaps.** Gaps in `in_valid` during `LOAD` are allowed and do not affect output skew.
- **Reset.**
  - While `rst` = 1, regardless of state: `sa_iv` = 0, `row_A_i` = 0, `in_ready` = 0, `tile_done` = 0, `cnt` = 0, `t` = 0.
  - `in_ready` = 1 from the first cycle after `rst` deasserts.
  - A reset during `STREAM` aborts the tile with no `tile_done` pulse.
- **`in_last` on a full tile.** `in_last` = 1 on the `VECTOR_LENGTH`-th vector is identical to a full tile.

## Test plan
- **Full tile, defaults.**
  - Stimulus: 8 vectors with row0 = 3, row1 = 2, row2 = 1, back-to-back.
  - Required: `sa_iv` high for 10 cycles.
  - Row 0: 3 for t = 0..7, 0 for t = 8..9.
  - Row 1: 0 at t = 0, 2 for t = 1..8, 0 at t = 9.
  - Row 2: 0 for t = 0..1, 1 for t = 2..9.
  - `tile_done` pulses on the cycle after t = 9.
- **Distinct elements.**
  - Stimulus: vector k = {row2: 30+k, row1: 20+k, row0: 10+k}, k = 0..7.
  - Required: at step t, `row_A_i[r]` = 10·(r+1) + t − r when 0 ≤ t−r ≤ 7, else 0. Check all 10 cycles.
- **Gapped input.**
  - Stimulus: same data as the full-tile case, with `in_valid` toggled 1/0 every cycle.
  - Required: identical skewed output, starting 1 cycle after the 8th accept.
  - `in_ready` = 1 throughout the gaps.
- **Short tile.**
  - Stimulus: 3 vectors of all −1 (8'hFF), `in_last` on the 3rd.
  - Required: 10-cycle stream.
  - Row r: 8'hFF for t = r..r+2, 0 elsewhere.
  - Slots 3..7 are zero even though the buffer holds stale data from the previous tile.
- **Back-to-back with stall.**
  - Stimulus: `in_valid` held high with a second tile queued behind the first.
  - Required: `in_ready` = 0 for exactly 10 cycles. No vector is accepted during `STREAM`. The second tile's first accept occurs in the `tile_done` cycle.
- **Reset mid-stream.**
  - Stimulus: assert `rst` for 1 cycle at t = 4.
  - Required: the next cycle has `sa_iv` = 0, `row_A_i` = 0, and no `tile_done`.
  - `in_ready` = 1 the cycle after `rst` drops.
  - A fresh full tile then streams correctly.

Source files
------------

// File: rtl/sa_row_feeder_if.sv
// Activation vector stream into the row feeder: one SA_ROW-wide vector per
// accepted beat, with an optional last flag that closes a short tile.
interface sa_row_feeder_if #(
    parameter int SA_ROW     = 3,
    parameter int DATA_WIDTH = 8
);
    logic                                in_valid;
    logic                                in_ready;
    logic                                in_last;
    logic [SA_ROW-1:0][DATA_WIDTH-1:0]   in_vec;

    modport master (output in_valid, output in_vec, output in_last, input in_ready);
    modport slave  (input in_valid, input in_vec, input in_last, output in_ready);
endinterface

// File: rtl/sa_row_feeder.sv
// Buffers one tile of activation vectors, then streams it diagonally skewed (row r delayed r cycles).
// Latency 1 cycle from final accept to t=0; in_ready low for the whole stream (VECTOR_LENGTH+SA_ROW-1 cycles).
module sa_row_feeder #(
    parameter int SA_ROW        = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_LENGTH = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    sa_row_feeder_if.slave                    i_in,
    output logic                              o_sa_iv,
    output logic [SA_ROW-1:0][DATA_WIDTH-1:0] o_row_A_i,
    output logic                              o_tile_done
);
    localparam int STEPS = VECTOR_LENGTH + SA_ROW - 1;
    localparam int CW    = $clog2(STEPS + 1);

    typedef logic [SA_ROW-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic {LOAD, STREAM} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_t;
    logic [CW-1:0]   r_nvec;
    vec_t            r_buf [VECTOR_LENGTH];
    logic            r_sa_iv;
    vec_t            r_row;
    logic            r_done;

    logic            w_accept;
    logic            w_final;
    vec_t            w_row;

    assign i_in.in_ready = (r_state == LOAD) && !i_rst;
    assign w_accept      = i_in.in_valid && i_in.in_ready;
    assign w_final       = (r_cnt == CW'(VECTOR_LENGTH - 1)) || i_in.in_last;

    assign o_sa_iv     = r_sa_iv;
    assign o_row_A_i   = r_row;
    assign o_tile_done = r_done;

    // Next output row: step t+1 while streaming, step 0 on the final accept.
    // Slots at or beyond r_nvec were never loaded in this tile and read as zero.
    always_comb begin
        w_row = '0;
        if (r_state == LOAD) begin
            w_row[0] = (r_cnt == '0) ? i_in.in_vec[0] : r_buf[0][0];
        end else begin
            for (int r = 0; r < SA_ROW; r++) begin
                for (int s = 0; s < VECTOR_LENGTH; s++) begin
                    if ((int'(r_t) + 1 == s + r) && (s < int'(r_nvec))) begin
                        w_row[r] = r_buf[s][r];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_t     <= '0;
            r_nvec  <= '0;
            r_sa_iv <= 1'b0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_final) begin
                            r_state <= STREAM;
                            r_nvec  <= r_cnt + 1'b1;
                            r_t     <= '0;
                            r_sa_iv <= 1'b1;
                            r_row   <= w_row;
                        end
                    end
                end
                STREAM: begin
                    if (r_t == CW'(STEPS - 1)) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        r_t     <= '0;
                        r_sa_iv <= 1'b0;
                        r_row   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t   <= r_t + 1'b1;
                        r_row <= w_row;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Tile storage is never cleared; the r_nvec bound masks stale slots.
    always_ff @(posedge i_clk) begin
        if ((r_state == LOAD) && w_accept) begin
            for (int s = 0; s < VECTOR_LENGTH; s++) begin
                if (r_cnt == CW'(s)) begin
                    r_buf[s] <= i_in.in_vec;
                end
            end
        end
    end
endmodule

// File: tb/tb_sa_row_feeder.sv
// Scoreboard bench for sa_row_feeder: stimulus queues expected skewed rows, a monitor checks every cycle.
module tb_sa_row_feeder;
    typedef logic [2:0][7:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sa_iv;
    logic tile_done;
    vec_t row_A_i;

    sa_row_feeder_if #(.SA_ROW(3), .DATA_WIDTH(8)) vif();

    sa_row_feeder #(.SA_ROW(3), .DATA_WIDTH(8), .VECTOR_LENGTH(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in        (vif),
        .o_sa_iv     (sa_iv),
        .o_row_A_i   (row_A_i),
        .o_tile_done (tile_done)
    );

    always #5 clk = ~clk;

    vec_t tvec [8];
    vec_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   m_prev_iv  = 1'b0;
    bit   m_prev_rst = 1'b1;
    bit   m_abort    = 1'b0;
    int   m_streak   = 0;
    vec_t m_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference skew: step t, row r carries vector t-r when it lies inside the loaded part of the tile.
    task automatic push_exp(input int n);
        for (int t = 0; t < 10; t++) begin
            vec_t e = '0;
            for (int r = 0; r < 3; r++) begin
                int s = t - r;
                if (s >= 0 && s < n) e[r] = tvec[s][r];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int n, input bit gap, input bit use_last, input bit chk_stall);
        for (int k = 0; k < n; k++) begin
            int waited = 0;
            bit acc = 1'b0;
            bit done_at_acc = 1'b0;
            vif.in_valid = 1'b1;
            vif.in_vec   = tvec[k];
            vif.in_last  = use_last && (k == n - 1);
            while (!acc && waited < 40) begin
                @(negedge clk);
                acc = vif.in_ready;
                done_at_acc = tile_done;
                if (!acc) waited++;
                @(posedge clk);
                #1;
            end
            chk("accepted", {31'd0, acc}, 32'd1);
            if (chk_stall && k == 0) begin
                chk("stall_cycles", waited, 10);
                chk("accept_in_done_cycle", {31'd0, done_at_acc}, 32'd1);
            end
            if (k == n - 1) begin
                push_exp(n);
            end else if (gap) begin
                vif.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        vif.in_valid = 1'b0;
        vif.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_const();
        for (int k = 0; k < 8; k++) tvec[k] = {8'd1, 8'd2, 8'd3};
    endtask

    task automatic fill_distinct();
        for (int k = 0; k < 8; k++) begin
            tvec[k][0] = 8'(10 + k);
            tvec[k][1] = 8'(20 + k);
            tvec[k][2] = 8'(30 + k);
        end
    endtask

    // Monitor: checks handshake/idle relations every cycle and pops one expected row per sa_iv cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (m_prev_rst) begin
                chk("rst_sa_iv", {31'd0, sa_iv}, 32'd0);
                chk("rst_row", {8'd0, row_A_i}, 32'd0);
            end
            chk("in_ready", {31'd0, vif.in_ready}, {31'd0, (!rst && sa_iv !== 1'b1)});
            chk("tile_done", {31'd0, tile_done}, {31'd0, (m_prev_iv && sa_iv !== 1'b1 && !m_prev_rst)});
            if (sa_iv === 1'b1) begin
                m_streak++;
                if (rst) m_abort = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_sa_iv", {31'd0, sa_iv}, 32'd0);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("row_A_i", {8'd0, row_A_i}, {8'd0, m_exp});
                end
            end else begin
                if (sa_iv !== 1'b0) chk("sa_iv_known", {31'd0, sa_iv}, 32'd0);
                if (m_prev_iv) begin
                    if (!m_abort) chk("stream_len", m_streak, 10);
                    m_streak = 0;
                    m_abort  = 1'b0;
                end
                chk("idle_row", {8'd0, row_A_i}, 32'd0);
            end
            m_prev_iv  = (sa_iv === 1'b1);
            m_prev_rst = rst;
        end
    end

    initial begin
        vif.in_valid = 1'b0;
        vif.in_last  = 1'b0;
        vif.in_vec   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fill_const();
        send(8, 1'b0, 1'b0, 1'b0);
        idle(12);

        fill_distinct();
        send(8, 1'b0, 1'b0, 1'b0);
        idle(12);

        fill_const();
        send(8, 1'b1, 1'b0, 1'b0);
        idle(12);

        // Second tile queued behind the first with in_valid held high.
        fill_distinct();
        send(8, 1'b0, 1'b0, 1'b0);
        fill_const();
        send(8, 1'b0, 1'b1, 1'b1);
        idle(12);

        // Short tile over a buffer still holding the previous tile.
        for (int k = 0; k < 3; k++) tvec[k] = {8'hFF, 8'hFF, 8'hFF};
        send(3, 1'b0, 1'b1, 1'b0);
        idle(12);

        // Reset during t = 4 aborts the tile.
        fill_distinct();
        send(8, 1'b0, 1'b0, 1'b0);
        idle(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        idle(3);
        fill_const();
        send(8, 1'b0, 1'b0, 1'b0);
        idle(12);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
